// File: rtl/trapez_peak_sampler_pkg.sv
// Shared settings for the trapezoid peak sampler.
// Holds the default widths, the frame FSM state type and the default-width event record layout.
package package_settings;

   localparam int unsigned SIZE_SHAPER_DATA = 16;
   localparam int unsigned SIZE_PEAK_LEN    = 10;
   localparam int unsigned SIZE_PEAK_TS     = 32;
   localparam int unsigned SIZE_PEAK_DROP   = 16;

   typedef enum logic [1:0] {IDLE, RISE, FLAT, FALL} peak_state_t;

   typedef struct packed {
      logic [SIZE_SHAPER_DATA-1:0] height;
      logic [SIZE_SHAPER_DATA-1:0] max;
      logic [SIZE_PEAK_TS-1:0]     ts;
      logic                        pileup;
   } peak_event_t;

endpackage

// File: rtl/trapez_peak_sampler_buffer.sv
// One-entry valid/ready holding register for committed event records.
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   push, push_rec   committed record from the frame FSM
//   ready            consumer accepts the held record
//   valid, rec       held record and its valid flag
//   drop_cnt         records lost because the entry was full, saturating
module peak_event_buffer #(
   parameter int unsigned REC_W  = 65,
   parameter int unsigned DROP_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [REC_W-1:0]  push_rec,
   input  logic              ready,
   output logic              valid,
   output logic [REC_W-1:0]  rec,
   output logic [DROP_W-1:0] drop_cnt
);

   logic              valid_q, valid_d;
   logic [REC_W-1:0]  rec_q, rec_d;
   logic [DROP_W-1:0] drop_q, drop_d;
   logic              pop;

   always_comb begin
      valid_d = valid_q;
      rec_d   = rec_q;
      drop_d  = drop_q;
      pop     = valid_q & ready;
      if (push && (!valid_q || pop)) begin
         // A pop in the same cycle frees the slot for the new record.
         valid_d = 1'b1;
         rec_d   = push_rec;
      end else if (push) begin
         if (drop_q != '1) begin
            drop_d = drop_q + DROP_W'(1);
         end
      end else if (pop) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         rec_q   <= '0;
         drop_q  <= '0;
      end else begin
         valid_q <= valid_d;
         rec_q   <= rec_d;
         drop_q  <= drop_d;
      end
   end

   assign valid    = valid_q;
   assign rec      = rec_q;
   assign drop_cnt = drop_q;

endmodule

// File: rtl/trapez_peak_sampler.sv
// Frames each trapezoid-shaped pulse from its trigger edge, samples the flat-top midpoint
// height and maximum, flags pile-up, timestamps the trigger and hands one record per pulse
// to the readout stage through a one-entry valid/ready buffer.
// Ports:
//   clk, reset                     system clock, synchronous active-high reset
//   enable                         0 aborts the current frame and holds the FSM idle
//   pulse_time                     trigger, rising edge starts a frame
//   shaper_data                    signed shaper output
//   rise_len, flat_len, threshold  frame parameters, latched at frame start
//   event_valid, event_ready       record handshake
//   event_height, event_max        flat-top midpoint sample and flat-top maximum
//   event_ts, event_pileup         trigger timestamp and pile-up flag
//   drop_cnt                       records lost to backpressure, saturating
module trapez_peak_sampler
   import package_settings::*;
#(
   parameter int unsigned DATA_W = SIZE_SHAPER_DATA,
   parameter int unsigned LEN_W  = SIZE_PEAK_LEN,
   parameter int unsigned TS_W   = SIZE_PEAK_TS,
   parameter int unsigned DROP_W = SIZE_PEAK_DROP
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              pulse_time,
   input  logic [DATA_W-1:0] shaper_data,
   input  logic [LEN_W-1:0]  rise_len,
   input  logic [LEN_W-1:0]  flat_len,
   input  logic [DATA_W-1:0] threshold,
   output logic              event_valid,
   input  logic              event_ready,
   output logic [DATA_W-1:0] event_height,
   output logic [DATA_W-1:0] event_max,
   output logic [TS_W-1:0]   event_ts,
   output logic              event_pileup,
   output logic [DROP_W-1:0] drop_cnt
);

   localparam int unsigned REC_W = 2 * DATA_W + TS_W + 1;

   peak_state_t       state_q, state_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [LEN_W-1:0]  rise_q, rise_d;
   logic [LEN_W-1:0]  flat_q, flat_d;
   logic [DATA_W-1:0] thr_q, thr_d;
   logic [TS_W-1:0]   ts_q, ts_d;
   logic [TS_W-1:0]   ts_lat_q, ts_lat_d;
   logic              pileup_q, pileup_d;
   logic [DATA_W-1:0] max_q, max_d;
   logic [DATA_W-1:0] height_q, height_d;
   logic              pt_prev_q, pt_prev_d;

   logic              trig;
   logic              cnt_last;
   logic [LEN_W-1:0]  len_cur;
   logic              commit;
   logic              push;
   logic [REC_W-1:0]  push_rec;
   logic [REC_W-1:0]  buf_rec;

   // Zero lengths would make an empty phase; they behave as one cycle.
   function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
      return (len == '0) ? LEN_W'(1) : len;
   endfunction

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rise_d    = rise_q;
      flat_d    = flat_q;
      thr_d     = thr_q;
      ts_d      = ts_q + TS_W'(1);
      ts_lat_d  = ts_lat_q;
      pileup_d  = pileup_q;
      max_d     = max_q;
      height_d  = height_q;
      pt_prev_d = pulse_time;
      commit    = 1'b0;

      trig     = pulse_time & ~pt_prev_q;
      len_cur  = (state_q == FLAT) ? flat_q : rise_q;
      cnt_last = (cnt_q == len_cur - LEN_W'(1));

      unique case (state_q)
         IDLE: begin
            if (enable && trig) begin
               state_d  = RISE;
               cnt_d    = '0;
               rise_d   = eff_len(rise_len);
               flat_d   = eff_len(flat_len);
               thr_d    = threshold;
               ts_lat_d = ts_q;
               pileup_d = 1'b0;
            end
         end
         RISE: begin
            if (trig) pileup_d = 1'b1;
            if (cnt_last) begin
               state_d = FLAT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + LEN_W'(1);
            end
         end
         FLAT: begin
            if (trig) pileup_d = 1'b1;
            if (cnt_q == '0 || $signed(shaper_data) > $signed(max_q)) begin
               max_d = shaper_data;
            end
            // Midpoint index floor((F-1)/2); F >= 1 so no underflow.
            if (cnt_q == ((flat_q - LEN_W'(1)) >> 1)) begin
               height_d = shaper_data;
            end
            if (cnt_last) begin
               state_d = FALL;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + LEN_W'(1);
            end
         end
         FALL: begin
            if (trig) pileup_d = 1'b1;
            if (cnt_last) begin
               state_d = IDLE;
               cnt_d   = '0;
               commit  = 1'b1;
            end else begin
               cnt_d = cnt_q + LEN_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Abort wins over everything, including a commit on the last FALL cycle.
      if (!enable) begin
         state_d = IDLE;
         cnt_d   = '0;
         commit  = 1'b0;
      end

      push     = commit & ($signed(max_q) >= $signed(thr_q));
      // pileup_d so an edge on the final FALL cycle is still reported.
      push_rec = {height_q, max_q, ts_lat_q, pileup_d};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rise_q    <= '0;
         flat_q    <= '0;
         thr_q     <= '0;
         ts_q      <= '0;
         ts_lat_q  <= '0;
         pileup_q  <= 1'b0;
         max_q     <= '0;
         height_q  <= '0;
         pt_prev_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rise_q    <= rise_d;
         flat_q    <= flat_d;
         thr_q     <= thr_d;
         ts_q      <= ts_d;
         ts_lat_q  <= ts_lat_d;
         pileup_q  <= pileup_d;
         max_q     <= max_d;
         height_q  <= height_d;
         pt_prev_q <= pt_prev_d;
      end
   end

   peak_event_buffer #(
      .REC_W  (REC_W),
      .DROP_W (DROP_W)
   ) u_buffer (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .push_rec (push_rec),
      .ready    (event_ready),
      .valid    (event_valid),
      .rec      (buf_rec),
      .drop_cnt (drop_cnt)
   );

   assign {event_height, event_max, event_ts, event_pileup} = buf_rec;

endmodule

// File: tb/tb_trapez_peak_sampler.sv
// Randomized and directed bench for trapez_peak_sampler with a frame-level reference model.
module tb_trapez_peak_sampler;

   localparam int MAXC = 8192;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        pulse_time;
   logic [15:0] shaper_data;
   logic [9:0]  rise_len;
   logic [9:0]  flat_len;
   logic [15:0] threshold;
   logic        event_valid;
   logic        event_ready;
   logic [15:0] event_height;
   logic [15:0] event_max;
   logic [31:0] event_ts;
   logic        event_pileup;
   logic [15:0] drop_cnt;

   trapez_peak_sampler dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .pulse_time   (pulse_time),
      .shaper_data  (shaper_data),
      .rise_len     (rise_len),
      .flat_len     (flat_len),
      .threshold    (threshold),
      .event_valid  (event_valid),
      .event_ready  (event_ready),
      .event_height (event_height),
      .event_max    (event_max),
      .event_ts     (event_ts),
      .event_pileup (event_pileup),
      .drop_cnt     (drop_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   // Input history, indexed by absolute cycle.
   logic signed [15:0] sd_hist  [MAXC];
   bit                 trg_hist [MAXC];

   // Reference model state: frame bounds plus the one-entry output slot.
   bit                 m_prev;
   logic [31:0]        m_ts;
   bit                 m_busy;
   int                 m_start, m_end, m_r, m_f;
   logic signed [15:0] m_thr;
   logic [31:0]        m_ts_lat;
   bit                 m_valid;
   logic [15:0]        m_h, m_m, m_drop;
   logic [31:0]        m_t;
   bit                 m_p;

   int flat_off [6];

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic model_step();
      bit                 trg, pop, push, pl;
      logic signed [15:0] mx, smp;
      logic [15:0]        ht;
      push = 1'b0;
      mx   = '0;
      ht   = '0;
      pl   = 1'b0;
      if (reset) begin
         m_prev  = 1'b0;
         m_ts    = '0;
         m_busy  = 1'b0;
         m_valid = 1'b0;
         m_drop  = '0;
         m_h     = '0;
         m_m     = '0;
         m_t     = '0;
         m_p     = 1'b0;
         trg_hist[cyc] = 1'b0;
         sd_hist[cyc]  = '0;
         cyc++;
         return;
      end
      trg = pulse_time && !m_prev;
      trg_hist[cyc] = trg;
      sd_hist[cyc]  = $signed(shaper_data);
      pop = m_valid && event_ready;
      if (m_busy) begin
         if (!enable) begin
            m_busy = 1'b0;
         end else if (cyc == m_end) begin
            m_busy = 1'b0;
            mx = sd_hist[m_start + m_r + 1];
            for (int k = 1; k < m_f; k++) begin
               smp = sd_hist[m_start + m_r + 1 + k];
               if (smp > mx) mx = smp;
            end
            ht = sd_hist[m_start + m_r + 1 + (m_f - 1) / 2];
            for (int k = m_start + 1; k <= cyc; k++) pl |= trg_hist[k];
            push = (mx >= m_thr);
         end
      end else if (trg && enable) begin
         m_busy   = 1'b1;
         m_start  = cyc;
         m_r      = (rise_len == 0) ? 1 : int'(rise_len);
         m_f      = (flat_len == 0) ? 1 : int'(flat_len);
         m_end    = cyc + 2 * m_r + m_f;
         m_thr    = $signed(threshold);
         m_ts_lat = m_ts;
      end
      if (push && (!m_valid || pop)) begin
         m_valid = 1'b1;
         m_h     = ht;
         m_m     = mx;
         m_t     = m_ts_lat;
         m_p     = pl;
      end else if (push) begin
         if (m_drop != 16'hffff) m_drop++;
      end else if (pop) begin
         m_valid = 1'b0;
      end
      m_prev = pulse_time;
      m_ts++;
      cyc++;
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      check_eq("valid", 64'(event_valid), 64'(m_valid));
      check_eq("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      if (m_valid) begin
         check_eq("height", 64'(event_height), 64'(m_h));
         check_eq("max", 64'(event_max), 64'(m_m));
         check_eq("ts", 64'(event_ts), 64'(m_t));
         check_eq("pileup", 64'(event_pileup), 64'(m_p));
      end
   endtask

   // Drives one trapezoid: edge at k=0, optional pile-up edge, ready pulse and abort.
   task automatic run_pulse(input int r, input int f, input int base, input int thr,
                            input int pile_k, input int ready_k, input int abort_k,
                            input int tail);
      int re, fe, total, sd;
      re    = (r == 0) ? 1 : r;
      fe    = (f == 0) ? 1 : f;
      total = 2 * re + fe + 1 + tail;
      rise_len  = 10'(r);
      flat_len  = 10'(f);
      threshold = 16'(thr);
      for (int k = 0; k < total; k++) begin
         pulse_time = (k == 0) || (k == pile_k);
         enable     = (k != abort_k);
         if (ready_k >= 0) event_ready = (k == ready_k);
         if (k == 0 || k > 2 * re + fe) sd = 0;
         else if (k <= re) sd = base * k / re;
         else if (k <= re + fe) sd = base + flat_off[(k - re - 1) % 6];
         else sd = base * (2 * re + fe + 1 - k) / re;
         shaper_data = 16'(sd);
         step();
      end
      pulse_time = 1'b0;
      enable     = 1'b1;
   endtask

   initial begin
      flat_off = '{0, 2, 5, 10, 3, 1};
      reset = 1'b1; enable = 1'b1; pulse_time = 1'b0; shaper_data = '0;
      rise_len = '0; flat_len = '0; threshold = '0; event_ready = 1'b0;
      step();
      step();
      check_eq("rst_valid", 64'(event_valid), 64'd0);
      check_eq("rst_drop", 64'(drop_cnt), 64'd0);
      check_eq("rst_ts", 64'(event_ts), 64'd0);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) step();

      // Nominal frame: edge at ts 10, record visible at ts 25.
      run_pulse(4, 6, 1000, 100, -1, -1, -1, 4);
      check_eq("t1_height", 64'(event_height), 64'd1005);
      check_eq("t1_max", 64'(event_max), 64'd1010);
      check_eq("t1_ts", 64'(event_ts), 64'd10);
      check_eq("t1_pileup", 64'(event_pileup), 64'd0);
      event_ready = 1'b1; step(); event_ready = 1'b0;

      // Below threshold: silently discarded.
      run_pulse(4, 6, 50, 100, -1, -1, -1, 4);
      check_eq("t2_valid", 64'(event_valid), 64'd0);
      check_eq("t2_drop", 64'(drop_cnt), 64'd0);

      // Second edge three cycles into the flat top.
      run_pulse(4, 6, 1000, 100, 8, -1, -1, 6);
      check_eq("t3_pileup", 64'(event_pileup), 64'd1);
      event_ready = 1'b1; step(); event_ready = 1'b0;
      for (int i = 0; i < 4; i++) step();
      check_eq("t3_single", 64'(event_valid), 64'd0);

      // Backpressure across two events: second one dropped.
      run_pulse(4, 6, 1000, 100, -1, -1, -1, 2);
      run_pulse(4, 6, 2000, 100, -1, -1, -1, 2);
      check_eq("t4_max", 64'(event_max), 64'd1010);
      check_eq("t4_drop", 64'(drop_cnt), 64'd1);
      event_ready = 1'b1; step(); event_ready = 1'b0;
      check_eq("t4_pop", 64'(event_valid), 64'd0);

      // Commit coinciding with a pop.
      run_pulse(3, 5, 1000, 100, -1, -1, -1, 2);
      run_pulse(3, 5, 2000, 100, -1, 11, -1, 2);
      check_eq("t5_valid", 64'(event_valid), 64'd1);
      check_eq("t5_max", 64'(event_max), 64'd2010);
      check_eq("t5_drop", 64'(drop_cnt), 64'd1);

      // Abort mid flat-top, then reset while a record is held.
      event_ready = 1'b0;
      run_pulse(4, 6, 3000, 100, -1, -1, 7, 4);
      check_eq("t6_kept", 64'(event_max), 64'd2010);
      check_eq("t6_drop", 64'(drop_cnt), 64'd1);
      reset = 1'b1; step(); step(); reset = 1'b0;
      check_eq("t6_valid", 64'(event_valid), 64'd0);
      check_eq("t6_rdrop", 64'(drop_cnt), 64'd0);
      check_eq("t6_height", 64'(event_height), 64'd0);

      // Zero lengths behave as one cycle; ts restarts at 0 after reset.
      run_pulse(0, 0, 500, 100, -1, -1, -1, 2);
      check_eq("z_ts", 64'(event_ts), 64'd0);
      check_eq("z_max", 64'(event_max), 64'd500);
      event_ready = 1'b1; step();

      for (int i = 0; i < 4000; i++) begin
         pulse_time  = ($urandom_range(0, 9) == 0);
         shaper_data = 16'($urandom);
         rise_len    = 10'($urandom_range(0, 5));
         flat_len    = 10'($urandom_range(0, 6));
         threshold   = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 200));
         enable      = ($urandom_range(0, 49) != 0);
         event_ready = ($urandom_range(0, 2) != 0);
         reset       = ($urandom_range(0, 499) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
